snake_step_sched: RTL and testbench

Sequencer for one game step of the two-snake game. On each game tick it:
- requests one move from both snake movers;
- scans every body segment of each snake against the other snake's head, one compare per cycle, so the comparator path stays short;
- publishes sticky per-snake stop flags and a game-over flag.

It sits between the tick generator, the snake movers and the game-state/display logic.

---
 rtl/snake_step_sched.sv | 173 +++++++++++++++++
 tb/tb_snake_step_sched.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_step_sched.sv
// One game step for two snakes: request a move, then check each head against the other snake's body one segment per cycle.
// Define SELF_COLLISION_EN to also flag a head that runs into its own body (segments 1..len-1).
module snake_step_sched #(
    parameter int max_len         = 16,
    parameter int num_len         = 10,
    parameter int max_len_bit_len = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         tick,
    input  logic                         move_ack,
    input  logic [max_len*num_len-1:0]   snake1,
    input  logic [max_len*num_len-1:0]   snake2,
    input  logic [max_len_bit_len-1:0]   len1,
    input  logic [max_len_bit_len-1:0]   len2,
    output logic                         move_req,
    output logic                         busy,
    output logic                         step_done,
    output logic                         should_stop1,
    output logic                         should_stop2,
    output logic                         game_over,
    output logic                         tick_overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MOVE,
        S_SCAN1,
        S_SCAN2,
        S_RESOLVE,
        S_HALT
    } state_t;

    localparam logic [max_len_bit_len-1:0] IDX_ONE = max_len_bit_len'(1);

    state_t                      state_q, state_d;
    logic [max_len_bit_len-1:0]  idx_q, idx_d;
    logic [max_len_bit_len-1:0]  len1_q, len1_d, len2_q, len2_d;
    logic [num_len-1:0]          head1_q, head1_d, head2_q, head2_d;
    logic                        hit1_q, hit1_d, hit2_q, hit2_d;
    logic                        stop1_q, stop1_d, stop2_q, stop2_d;
    logic                        over_q, over_d;
    logic                        overrun_q, overrun_d;
    logic                        done_q, done_d;

    logic [num_len-1:0] seg1 [max_len];
    logic [num_len-1:0] seg2 [max_len];

    generate
        for (genvar gi = 0; gi < max_len; gi++) begin : g_unpack
            assign seg1[gi] = snake1[gi*num_len +: num_len];
            assign seg2[gi] = snake2[gi*num_len +: num_len];
        end
    endgenerate

    logic last1, last2;
    // A zero-length snake still spends one scan cycle, so the step length never collapses.
    assign last1 = (len1_q == '0) || (idx_q == len1_q - IDX_ONE);
    assign last2 = (len2_q == '0) || (idx_q == len2_q - IDX_ONE);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        len1_d    = len1_q;
        len2_d    = len2_q;
        head1_d   = head1_q;
        head2_d   = head2_q;
        hit1_d    = hit1_q;
        hit2_d    = hit2_q;
        stop1_d   = stop1_q;
        stop2_d   = stop2_q;
        over_d    = over_q;
        done_d    = 1'b0;
        // The step_done cycle is still treated as the tail of the old step.
        overrun_d = overrun_q | (tick & ((state_q != S_IDLE) | done_q));

        case (state_q)
            S_IDLE: begin
                if (tick && !over_q && !done_q) state_d = S_MOVE;
            end
            S_MOVE: begin
                if (move_ack) begin
                    len1_d  = len1;
                    len2_d  = len2;
                    head1_d = seg1[0];
                    head2_d = seg2[0];
                    hit1_d  = 1'b0;
                    hit2_d  = 1'b0;
                    idx_d   = '0;
                    state_d = S_SCAN1;
                end
            end
            S_SCAN1: begin
                if (idx_q < len1_q) begin
                    if (seg1[idx_q] == head2_q) hit2_d = 1'b1;
`ifdef SELF_COLLISION_EN
                    if (idx_q != '0 && seg1[idx_q] == head1_q) hit1_d = 1'b1;
`endif
                end
                if (last1) begin
                    idx_d   = '0;
                    state_d = S_SCAN2;
                end else begin
                    idx_d = idx_q + IDX_ONE;
                end
            end
            S_SCAN2: begin
                if (idx_q < len2_q) begin
                    if (seg2[idx_q] == head1_q) hit1_d = 1'b1;
`ifdef SELF_COLLISION_EN
                    if (idx_q != '0 && seg2[idx_q] == head2_q) hit2_d = 1'b1;
`endif
                end
                if (last2) begin
                    idx_d   = '0;
                    state_d = S_RESOLVE;
                end else begin
                    idx_d = idx_q + IDX_ONE;
                end
            end
            S_RESOLVE: begin
                stop1_d = stop1_q | hit1_q;
                stop2_d = stop2_q | hit2_q;
                over_d  = over_q | hit1_q | hit2_q;
                done_d  = 1'b1;
                state_d = (hit1_q || hit2_q) ? S_HALT : S_IDLE;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            len1_q    <= '0;
            len2_q    <= '0;
            head1_q   <= '0;
            head2_q   <= '0;
            hit1_q    <= 1'b0;
            hit2_q    <= 1'b0;
            stop1_q   <= 1'b0;
            stop2_q   <= 1'b0;
            over_q    <= 1'b0;
            overrun_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            len1_q    <= len1_d;
            len2_q    <= len2_d;
            head1_q   <= head1_d;
            head2_q   <= head2_d;
            hit1_q    <= hit1_d;
            hit2_q    <= hit2_d;
            stop1_q   <= stop1_d;
            stop2_q   <= stop2_d;
            over_q    <= over_d;
            overrun_q <= overrun_d;
            done_q    <= done_d;
        end
    end

    assign move_req     = (state_q == S_MOVE);
    assign busy         = (state_q != S_IDLE);
    assign step_done    = done_q;
    assign should_stop1 = stop1_q;
    assign should_stop2 = stop2_q;
    assign game_over    = over_q;
    assign tick_overrun = overrun_q;

endmodule

// File: tb/tb_snake_step_sched.sv
// Directed bench for snake_step_sched: expected step outcomes are queued at tick time and checked at step_done.
module tb_snake_step_sched;

    localparam int ML = 16;
    localparam int NL = 10;
    localparam int LB = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              tick;
    logic              move_ack;
    logic [ML*NL-1:0]  snake1;
    logic [ML*NL-1:0]  snake2;
    logic [LB-1:0]     len1;
    logic [LB-1:0]     len2;
    logic              move_req;
    logic              busy;
    logic              step_done;
    logic              should_stop1;
    logic              should_stop2;
    logic              game_over;
    logic              tick_overrun;

    snake_step_sched #(
        .max_len(ML),
        .num_len(NL),
        .max_len_bit_len(LB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tick(tick),
        .move_ack(move_ack),
        .snake1(snake1),
        .snake2(snake2),
        .len1(len1),
        .len2(len2),
        .move_req(move_req),
        .busy(busy),
        .step_done(step_done),
        .should_stop1(should_stop1),
        .should_stop2(should_stop2),
        .game_over(game_over),
        .tick_overrun(tick_overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       s1;
        logic       s2;
        logic       go;
        logic [7:0] lat;
    } exp_t;

    exp_t          exp_q[$];
    int            vectors     = 0;
    int            miscompares = 0;
    logic [NL-1:0] s1seg [ML];
    logic [NL-1:0] s2seg [ML];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load_default();
        for (int i = 0; i < ML; i++) begin
            s1seg[i] = NL'(32'h100 + i);
            s2seg[i] = NL'(32'h200 + i);
        end
    endtask

    task automatic pack();
        for (int i = 0; i < ML; i++) begin
            snake1[i*NL +: NL] = s1seg[i];
            snake2[i*NL +: NL] = s2seg[i];
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        tick     = 1'b0;
        move_ack = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_move_req"}, 32'(move_req), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_step_done"}, 32'(step_done), 0);
        chk({tag, "_stop1"}, 32'(should_stop1), 0);
        chk({tag, "_stop2"}, 32'(should_stop2), 0);
        chk({tag, "_game_over"}, 32'(game_over), 0);
        chk({tag, "_overrun"}, 32'(tick_overrun), 0);
    endtask

    task automatic run_step(input string tag, input logic [LB-1:0] l1, input logic [LB-1:0] l2,
                            input int ack_dly, input bit mid_tick,
                            input logic e1, input logic e2, input logic [7:0] elat);
        exp_t e;
        exp_t got;
        int   c;
        pack();
        len1  = l1;
        len2  = l2;
        e.s1  = e1;
        e.s2  = e2;
        e.go  = e1 | e2;
        e.lat = elat;
        exp_q.push_back(e);
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        chk({tag, "_move_req_rise"}, 32'(move_req), 1);
        chk({tag, "_busy"}, 32'(busy), 1);
        repeat (ack_dly) cyc();
        chk({tag, "_move_req_held"}, 32'(move_req), 1);
        move_ack = 1'b1;
        cyc();
        move_ack = 1'b0;
        c = 1;
        chk({tag, "_move_req_fall"}, 32'(move_req), 0);
        while (!step_done && c < 64) begin
            tick = mid_tick && (c == 1);
            cyc();
            c++;
        end
        tick = 1'b0;
        got = exp_q.pop_front();
        if (!step_done) begin
            chk({tag, "_step_done_timeout"}, 32'(step_done), 1);
        end else begin
            chk({tag, "_latency"}, 32'(c), 32'(got.lat));
            chk({tag, "_stop1"}, 32'(should_stop1), 32'(got.s1));
            chk({tag, "_stop2"}, 32'(should_stop2), 32'(got.s2));
            chk({tag, "_game_over"}, 32'(game_over), 32'(got.go));
        end
        cyc();
        chk({tag, "_step_done_pulse"}, 32'(step_done), 0);
        chk({tag, "_busy_after"}, 32'(busy), 32'(got.go));
    endtask

    initial begin
        rst      = 1'b1;
        tick     = 1'b0;
        move_ack = 1'b0;
        len1     = '0;
        len2     = '0;
        load_default();
        pack();

        do_reset();
        chk_all_zero("reset");

        // Disjoint snakes, ack two cycles after the request.
        load_default();
        run_step("disjoint", 4'd3, 4'd3, 2, 1'b0, 1'b0, 1'b0, 8'd8);
        chk("disjoint_overrun", 32'(tick_overrun), 0);

        // head2 lands on snake1 segment 2.
        load_default();
        s1seg[2] = 10'h05A;
        s2seg[0] = 10'h05A;
        run_step("hit2", 4'd4, 4'd3, 2, 1'b0, 1'b0, 1'b1, 8'd9);
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        chk("halt_tick_move_req", 32'(move_req), 0);
        chk("halt_tick_overrun", 32'(tick_overrun), 1);
        cyc();
        chk("halt_tick_move_req_later", 32'(move_req), 0);
        chk("halt_busy", 32'(busy), 1);

        // Head-to-head collision.
        do_reset();
        load_default();
        s1seg[0] = 10'h123;
        s2seg[0] = 10'h123;
        run_step("head2head", 4'd2, 4'd2, 1, 1'b0, 1'b1, 1'b1, 8'd6);

        // Empty snake1, head1 matches snake2 segment 4.
        do_reset();
        load_default();
        s1seg[0] = 10'h0AB;
        s2seg[4] = 10'h0AB;
        run_step("len0", 4'd0, 4'd5, 2, 1'b0, 1'b1, 1'b0, 8'd8);

        // Match sits in slot 6, just past len1; tick arrives during SCAN1.
        do_reset();
        load_default();
        s1seg[6] = 10'h200;
        run_step("beyond_len", 4'd6, 4'd2, 0, 1'b1, 1'b0, 1'b0, 8'd10);
        chk("beyond_len_overrun", 32'(tick_overrun), 1);

        // head1 equals its own segment 3.
        load_default();
        s1seg[3] = 10'h100;
`ifdef SELF_COLLISION_EN
        run_step("self", 4'd5, 4'd2, 1, 1'b0, 1'b1, 1'b0, 8'd9);
`else
        run_step("self", 4'd5, 4'd2, 1, 1'b0, 1'b0, 1'b0, 8'd9);
`endif

        // Reset in the middle of SCAN2.
        do_reset();
        load_default();
        pack();
        len1 = 4'd2;
        len2 = 4'd5;
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        cyc();
        move_ack = 1'b1;
        cyc();
        move_ack = 1'b0;
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        cyc();
        chk("midscan_busy", 32'(busy), 1);
        chk("midscan_overrun", 32'(tick_overrun), 1);
        rst = 1'b1;
        cyc();
        chk_all_zero("midscan_rst");
        rst = 1'b0;

        load_default();
        run_step("recover", 4'd3, 4'd3, 2, 1'b0, 1'b0, 1'b0, 8'd8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
